display7_scan: RTL and testbench

Time-multiplexed scan controller for an 8-digit common-anode 7-segment display. Holds a 32-bit hex value (8 nibbles), selects one digit at a time, and drives one shared active-low segment decoder. It sits between the user-logic value source and the board's anode/segment pins, and handles refresh timing, inter-digit ghost blanking, tear-free value updates and leading-zero suppression.

---
 rtl/display7_pkg.sv | 31 +++
 rtl/display7_scan_if.sv | 13 +
 rtl/display7_scan_seg7_dec.sv | 26 ++
 rtl/display7_scan.sv | 136 +++++++++++++
 tb/tb_display7_scan.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/display7_pkg.sv
// Shared types, glyph constants and width helpers for the 7-segment scan controller.
package display7_pkg;

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  // Active-low glyphs, bit6 = g ... bit0 = a.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int clog2w(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++)
      if ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/display7_scan_if.sv
// Value-source / pin-side signal bundle of the scan controller.
interface display7_scan_if;
  logic        iEn;
  logic        iLzs;
  logic        iLoad;
  logic [31:0] iData;
  logic [7:0]  oSel;
  logic [6:0]  oSeg;
  logic        oPend;

  modport master (output iEn, iLzs, iLoad, iData, input oSel, oSeg, oPend);
  modport slave  (input iEn, iLzs, iLoad, iData, output oSel, oSeg, oPend);
endinterface

// File: rtl/display7_scan_seg7_dec.sv
// Nibble to active-low 7-segment glyph; 10..15 deliberately decode to blank.
module seg7_dec
  import display7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display7_scan.sv
// 8-digit multiplexed display scanner: SHOW/GAP sequencer, frame-aligned value
// commit, leading-zero suppression and registered anode/segment outputs.
module display7_scan
  import display7_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000,
  parameter int GAP    = 2
) (
  input  logic            clk,
  input  logic            rst,
  display7_scan_if.slave  bus
);

  localparam int CW = clog2w((DIV > GAP) ? DIV : GAP);
  localparam int IW = clog2w(DIGITS);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   act_q, act_d;
  logic [31:0]   pval_q, pval_d;
  logic          pend_q, pend_d;
  logic [7:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic          commit;

  logic [7:0][3:0] nib;
  logic [7:0]      lz_blank;
  logic [6:0]      dec_seg;

  assign nib = act_q;

  // Digit k blanks when it and every used digit above it are zero; digit 0 never blanks.
  for (genvar k = 0; k < 8; k++) begin : g_lz
    if (k == 0 || k >= DIGITS) begin : g_never
      assign lz_blank[k] = 1'b0;
    end else begin : g_chk
      localparam logic [31:0] ZMASK =
        (32'hFFFF_FFFF >> (4 * (8 - DIGITS))) & (32'hFFFF_FFFF << (4 * k));
      assign lz_blank[k] = ((act_q & ZMASK) == 32'h0);
    end
  end

  seg7_dec u_dec (
    .nib_i (nib[idx_q]),
    .seg_o (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    sel_d   = 8'hFF;
    seg_d   = SEG_BLANK;
    commit  = 1'b0;

    if (!bus.iEn) begin
      state_d = ST_SHOW;
      idx_d   = '0;
      cnt_d   = '0;
      commit  = pend_q;
    end else begin
      unique case (state_q)
        ST_SHOW: begin
          sel_d = ~(8'd1 << idx_q);
          seg_d = (bus.iLzs && lz_blank[idx_q]) ? SEG_BLANK : dec_seg;
          if (cnt_q == DIV_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              commit = pend_q;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_SHOW;
      endcase
    end

    // Commit consumes the old pending value; a same-cycle load then re-arms pend.
    if (commit) begin
      act_d  = pval_q;
      pend_d = 1'b0;
    end
    if (bus.iLoad) begin
      pval_d = bus.iData;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SHOW;
      idx_q   <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      sel_q   <= 8'hFF;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.oSel  = sel_q;
  assign bus.oSeg  = seg_q;
  assign bus.oPend = pend_q;

endmodule

// File: tb/tb_display7_scan.sv
// Directed + randomized bench for display7_scan against a frame-position model.
module tb_display7_scan;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int GAP    = 1;
  localparam int SLOT   = DIV + GAP;
  localparam int FRAME  = DIGITS * SLOT;

  logic clk;
  logic rst;
  display7_scan_if bus ();

  display7_scan #(.DIGITS(DIGITS), .DIV(DIV), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: cycles since scan start, displayed value, pending value/flag.
  int          t;
  logic [31:0] m_act, m_pval;
  bit          m_pend;
  logic [7:0]  e_sel;
  logic [6:0]  e_seg;
  bit          e_pend;
  logic [6:0]  gly [16];

  function automatic logic [6:0] glyph_of(int k, logic [31:0] v, bit lzs);
    logic [3:0] n;
    n = 4'((v >> (4 * k)) & 32'hF);
    if (lzs && k != 0 && (v >> (4 * k)) == 32'h0) return 7'h7F;
    return gly[n];
  endfunction

  task automatic cyc();
    int p, slot;
    @(posedge clk);
    e_sel = 8'hFF;
    e_seg = 7'h7F;
    if (rst) begin
      m_act = 0; m_pval = 0; m_pend = 0; t = 0;
    end else begin
      if (!bus.iEn) begin
        t = 0;
        if (m_pend) begin m_act = m_pval; m_pend = 0; end
      end else begin
        p    = t % FRAME;
        slot = p / SLOT;
        if (p % SLOT < DIV) begin
          e_sel = 8'hFF & ~(8'd1 << slot);
          e_seg = glyph_of(slot, m_act, bus.iLzs);
        end
        t++;
        if (t % FRAME == 0 && m_pend) begin m_act = m_pval; m_pend = 0; end
      end
      if (bus.iLoad) begin m_pval = bus.iData; m_pend = 1; end
    end
    e_pend = m_pend;
    @(negedge clk);
    vectors++;
    assert (bus.oSel === e_sel) else begin
      miscompares++;
      $error("FAIL sel t=%0d got %h exp %h", t, bus.oSel, e_sel);
    end
    assert (bus.oSeg === e_seg) else begin
      miscompares++;
      $error("FAIL seg t=%0d got %h exp %h", t, bus.oSeg, e_seg);
    end
    assert (bus.oPend === e_pend) else begin
      miscompares++;
      $error("FAIL pend t=%0d got %b exp %b", t, bus.oPend, e_pend);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < 8; i++)
      if ($urandom_range(2) != 0) v |= 32'($urandom_range(15)) << (4 * i);
    if ($urandom_range(3) == 0) v &= 32'h0000_0FFF;
    return v;
  endfunction

  initial begin
    gly = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    t = 0; m_act = 0; m_pval = 0; m_pend = 0;
    rst = 1'b1;
    bus.iEn = 1'b0; bus.iLzs = 1'b0; bus.iLoad = 1'b0; bus.iData = 32'h0;
    @(negedge clk);
    repeat (2) cyc();

    // Plain scan of value 0.
    rst = 1'b0; bus.iEn = 1'b1;
    repeat (FRAME + 5) cyc();

    // Mid-frame load, then shown from the next frame.
    repeat (7) cyc();
    bus.iLoad = 1'b1; bus.iData = 32'h0000_1234; cyc(); bus.iLoad = 1'b0;
    repeat (2 * FRAME) cyc();

    // Leading-zero suppression on the same value, then on 0.
    bus.iLzs = 1'b1;
    repeat (FRAME) cyc();
    bus.iLoad = 1'b1; bus.iData = 32'h0; cyc(); bus.iLoad = 1'b0;
    repeat (2 * FRAME) cyc();
    bus.iLzs = 1'b0;

    // Second load lands on the boundary edge: old pending commits, new stays pending.
    bus.iLoad = 1'b1; bus.iData = 32'h1111_1111; cyc(); bus.iLoad = 1'b0;
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) cyc();
    bus.iLoad = 1'b1; bus.iData = 32'h2222_2222; cyc(); bus.iLoad = 1'b0;
    repeat (2 * FRAME + 2) cyc();

    // Hex nibbles decode blank.
    bus.iLoad = 1'b1; bus.iData = 32'hABCD_EF98; cyc(); bus.iLoad = 1'b0;
    repeat (2 * FRAME) cyc();

    // Reset during digit 5 with a pending load.
    for (int i = 0; i < FRAME && (t % FRAME) != 5 * SLOT + 1; i++) cyc();
    bus.iLoad = 1'b1; bus.iData = 32'h8765_4321; cyc(); bus.iLoad = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (FRAME + 3) cyc();

    // Disabled: dark, pending commits immediately.
    bus.iEn = 1'b0;
    repeat (3) cyc();
    bus.iLoad = 1'b1; bus.iData = 32'h0000_0567; cyc(); bus.iLoad = 1'b0;
    repeat (3) cyc();
    bus.iEn = 1'b1;
    repeat (FRAME + 2) cyc();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(299) == 0);
      bus.iEn   = ($urandom_range(59) != 0);
      if ($urandom_range(49) == 0) bus.iLzs = ~bus.iLzs;
      bus.iLoad = ($urandom_range(29) == 0);
      bus.iData = rnd_val();
      cyc();
    end
    rst = 1'b0; bus.iLoad = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
